// File: rtl/bitwise_pipe_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_pkg
// Brief    : Opcode encoding shared by the bitwise pipeline unit and its ALU.
// Revision : 1.0 - initial release
// ============================================================================
package bitwise_pkg;

   localparam int BW_OP_W = 3;

   typedef enum logic [BW_OP_W-1:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_NAND  = 3'd2,
      OP_NOR   = 3'd3,
      OP_XOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_NOTA  = 3'd6,
      OP_PASSB = 3'd7
   } bw_op_e;

endpackage
`default_nettype wire

// File: rtl/bitwise_pipe_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_pipe_unit_if
// Brief    : Operand/result handshake bundle for the bitwise pipeline unit.
// Revision : 1.0 - initial release
// ============================================================================
interface bitwise_pipe_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic                            in_valid;
   logic                            in_ready;
   logic [bitwise_pkg::BW_OP_W-1:0] in_op;
   logic [WIDTH-1:0]                in_a;
   logic [WIDTH-1:0]                in_b;
   logic                            out_valid;
   logic                            out_ready;
   logic [WIDTH-1:0]                out_y;
   logic                            out_zero;
   logic                            out_parity;
   logic [CNT_W-1:0]                op_count;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_y, out_zero, out_parity, op_count
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_y, out_zero, out_parity, op_count
   );
endinterface
`default_nettype wire

// File: rtl/bitwise_pipe_unit_alu.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_alu
// Brief    : Combinational per-bit logic operation selected by opcode.
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_alu
   import bitwise_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  bw_op_e           i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      o_y = '0;
      case (i_op)
         OP_AND:   o_y = i_a & i_b;
         OP_OR:    o_y = i_a | i_b;
         OP_NAND:  o_y = ~(i_a & i_b);
         OP_NOR:   o_y = ~(i_a | i_b);
         OP_XOR:   o_y = i_a ^ i_b;
         OP_XNOR:  o_y = ~(i_a ^ i_b);
         OP_NOTA:  o_y = ~i_a;
         OP_PASSB: o_y = i_b;
         default:  o_y = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bitwise_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_pipe_unit
// Brief    : Two-stage valid/ready pipeline around bitwise_alu with result
//            flags and a saturating completed-operation counter.
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_pipe_unit
   import bitwise_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   bitwise_pipe_unit_if.slave  bus
);

   logic             r_s1_valid;
   bw_op_e           r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_y;
   logic             r_s2_zero;
   logic             r_s2_parity;
   logic [CNT_W-1:0] r_op_count;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_emit;
   logic             w_s2_load;
   logic [WIDTH-1:0] w_alu_y;

   // Ready never looks at in_valid, so upstream may gate valid on ready freely.
   assign w_in_ready = !rst && (!r_s1_valid || !r_s2_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_emit     = r_s2_valid && bus.out_ready;
   assign w_s2_load  = r_s1_valid && (!r_s2_valid || bus.out_ready);

   bitwise_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .i_op (r_s1_op),
      .i_a  (r_s1_a),
      .i_b  (r_s1_b),
      .o_y  (w_alu_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= OP_AND;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_op    <= bw_op_e'(bus.in_op);
         r_s1_a     <= bus.in_a;
         r_s1_b     <= bus.in_b;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_y      <= '0;
         r_s2_zero   <= 1'b0;
         r_s2_parity <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid  <= 1'b1;
         r_s2_y      <= w_alu_y;
         r_s2_zero   <= (w_alu_y == '0);
         r_s2_parity <= ^w_alu_y;
      end else if (w_emit) begin
         r_s2_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_count <= '0;
      end else if (w_emit && (r_op_count != {CNT_W{1'b1}})) begin
         r_op_count <= r_op_count + 1'b1;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_s2_valid;
   assign bus.out_y      = r_s2_y;
   assign bus.out_zero   = r_s2_zero;
   assign bus.out_parity = r_s2_parity;
   assign bus.op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_pipe_unit
// Brief    : Directed bench with an in-order transaction model for the unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_pipe_unit;

   localparam int W  = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bitwise_pipe_unit_if #(.WIDTH(W), .CNT_W(CW)) bus  ();
   bitwise_pipe_unit_if #(.WIDTH(1), .CNT_W(CW)) bus1 ();

   bitwise_pipe_unit #(.WIDTH(W), .CNT_W(CW)) dut  (.clk(clk), .rst(rst), .bus(bus));
   bitwise_pipe_unit #(.WIDTH(1), .CNT_W(CW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct {
      logic [W-1:0] y;
      int           acc;
   } item_t;

   item_t       mq[$];
   logic [9:0]  got[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   int          mcnt = 0;
   bit          exp_ready;
   bit          exp_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [W-1:0] model_y(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] ones;
      ones = '1;
      case (op)
         0: return a & b;
         1: return a | b;
         2: return ones ^ (a & b);
         3: return ones ^ (a | b);
         4: return a ^ b;
         5: return ones ^ (a ^ b);
         6: return ones ^ a;
         default: return b;
      endcase
   endfunction

   // Model: a result becomes visible two cycles after acceptance, heads first.
   always @(negedge clk) begin
      cyc++;
      exp_ready = !rst && (mq.size() < 2 || bus.out_ready);
      exp_valid = mq.size() > 0 && cyc >= mq[0].acc + 2;
      check("in_ready", bus.in_ready, exp_ready);
      check("out_valid", bus.out_valid, exp_valid);
      check("op_count", bus.op_count, mcnt);
      if (exp_valid) begin
         check("out_y", bus.out_y, mq[0].y);
         check("out_zero", bus.out_zero, (mq[0].y == 0));
         check("out_parity", bus.out_parity, $countones(mq[0].y) % 2);
      end
      if (rst) begin
         mq.delete();
         mcnt = 0;
      end else begin
         if (exp_valid && bus.out_ready) begin
            got.push_back({bus.out_parity, bus.out_zero, bus.out_y});
            void'(mq.pop_front());
            if (mcnt < (1 << CW) - 1) mcnt++;
         end
         if (bus.in_valid && exp_ready)
            mq.push_back('{model_y(int'(bus.in_op), bus.in_a, bus.in_b), cyc});
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit took;
      took = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op    = op[2:0];
      bus.in_a     = a;
      bus.in_b     = b;
      for (int i = 0; i < 50 && !took; i++) begin
         @(negedge clk);
         took = bus.in_ready;
         @(posedge clk);
         #1;
      end
      if (!took) check("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && mq.size() != 0; i++) idle(1);
      if (mq.size() != 0) check("drain_timeout", 0, 1);
   endtask

   initial begin
      int base;
      int start;
      logic [9:0] exp1 [8];
      logic [7:0] exp3 [4];
      exp1 = '{10'h100, 10'h0FF, 10'h0FF, 10'h100, 10'h0FF, 10'h100, 10'h03A, 10'h03A};
      exp3 = '{8'h30, 8'h99, 8'h5A, 8'hF0};

      bus.in_valid  = 1'b0; bus.in_op  = '0; bus.in_a  = '0; bus.in_b  = '0; bus.out_ready  = 1'b1;
      bus1.in_valid = 1'b0; bus1.in_op = '0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_op_count", bus.op_count, 0);

      // 1: opcode sweep
      base = got.size();
      for (int op = 0; op < 8; op++) send(op, 8'hC5, 8'h3A);
      drain();
      if (got.size() < base + 8) check("sweep_count", got.size() - base, 8);
      else for (int i = 0; i < 8; i++) check($sformatf("sweep_op%0d", i), got[base + i], exp1[i]);

      // 2: back-to-back stream, counter saturation
      start = cyc;
      for (int i = 0; i < 16; i++) send(i % 8, 8'(i * 17), 8'h0F);
      check("stream_cycles", cyc - start, 16);
      drain();
      idle(1);
      check("sat_count", bus.op_count, 15);

      // 3: backpressure
      base = got.size();
      bus.out_ready = 1'b0;
      send(0, 8'hF0, 8'h3C);
      send(1, 8'h81, 8'h18);
      bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_a = 8'h55; bus.in_b = 8'h0F;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_hold_y", bus.out_y, 8'h30);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(4, 8'h55, 8'h0F);
      send(6, 8'h0F, 8'h00);
      drain();
      if (got.size() < base + 4) check("bp_count", got.size() - base, 4);
      else for (int i = 0; i < 4; i++) check($sformatf("bp_order%0d", i), got[base + i][7:0], exp3[i]);

      // 4: accept and emit together on a full pipe
      bus.out_ready = 1'b0;
      send(2, 8'hFF, 8'h0F);
      send(3, 8'h00, 8'h00);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_op = 3'd5; bus.in_a = 8'hAA; bus.in_b = 8'h55;
      @(negedge clk);
      check("full_in_ready", bus.in_ready, 1);
      check("full_out_y", bus.out_y, 8'hF0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("no_bubble", bus.out_valid, 1);
      check("no_bubble_y", bus.out_y, 8'hFF);
      drain();

      // 5: reset with two in flight
      send(0, 8'hFF, 8'hFF);
      send(1, 8'h01, 8'h02);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_count", bus.op_count, 0);
      base = got.size();
      idle(4);
      check("midrst_discard", got.size() - base, 0);
      send(7, 8'h00, 8'h6C);
      drain();
      idle(1);
      check("post_rst_n", got.size() - base, 1);
      if (got.size() > base) check("post_rst_y", got[base][7:0], 8'h6C);
      check("post_rst_count", bus.op_count, 1);

      // 6: single-bit build, bitwise inversion
      bus1.in_valid = 1'b1; bus1.in_op = 3'd6; bus1.in_a = 1'b0; bus1.in_b = 1'b0;
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("w1_valid", bus1.out_valid, 1);
      check("w1_y", bus1.out_y, 1);
      check("w1_zero", bus1.out_zero, 0);
      check("w1_parity", bus1.out_parity, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/bitwise_pipe_unit.md
Name: bitwise_pipe_unit

Overview:
- Parametrised, registered successor to the team's combinational bitwise operator block.
- Applies one of eight per-bit logic operations to two WIDTH-bit operands, selected per transaction by an opcode.
- Two-stage pipeline with valid/ready handshakes on input and output, full throughput, and result flags.
- Sits between the operand-fetch stage and the writeback/result FIFO of the logic datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand transaction valid
- in_ready  output  1  unit can accept a transaction this cycle
- in_op  input  3  opcode (see Behaviour)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_parity  output  1  XOR-reduction of out_y
- op_count  output  CNT_W  number of results accepted downstream, saturating

Behaviour:
- Reset: synchronous, active-high; clk is the only clock. On rst, s1_valid, s2_valid, out_valid, out_y, out_zero, out_parity and op_count all clear to 0.
- Reset mid-operation: all in-flight transactions are discarded; nothing is emitted afterwards.
- in_ready is 0 during the rst cycle. It is combinational afterwards (see below).
- Opcodes, all bitwise across WIDTH bits; no logical (1-bit) negation anywhere:
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 NAND: ~(A&B)
  - 3 NOR: ~(A|B)
  - 4 XOR: A^B
  - 5 XNOR: ~(A^B)
  - 6 NOTA: ~A (B ignored)
  - 7 PASSB: B (A ignored)
- Stage 1 register: captures op, A, B when in_valid && in_ready.
- Stage 2 register: holds the computed result, zero flag and parity flag. It drives out_y, out_zero and out_parity directly; out_valid = s2_valid.
- Output transfer occurs when out_valid && out_ready.
- Advance rules:
  - s2 loads from s1 when s1_valid && (!s2_valid || out_ready).
  - s2_valid clears when the output transfers and s1 is empty.
  - in_ready = !s1_valid || !s2_valid || out_ready. Combinational from out_ready and internal state only; no path from in_valid.
- Latency: a transaction accepted in cycle N appears with out_valid=1 in cycle N+2 when out_ready is held high. Throughput is 1 per cycle.
- Backpressure: while out_valid && !out_ready, out_y, out_zero and out_parity hold stable. The pipeline stalls with at most 2 transactions held; in_ready drops once both stages are full.
- Simultaneous accept and emit on a full pipeline: both transfers occur in the same cycle with no bubble and no loss.
- Ordering: strict in-order delivery.
- op_count increments by 1 on each output transfer and saturates at 2^CNT_W-1 (no wrap).
- Unknown opcodes cannot occur (3-bit field is fully decoded).

Decomposition:
- Shared package bitwise_pkg holds:
  - typedef bw_op_e, 3-bit enum: OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_NOTA, OP_PASSB
  - constant BW_OP_W = 3
- One natural combinational sub-module, bitwise_alu, computes y from op, a and b, parameterised by WIDTH.
- Pipeline registers, handshake and counter stay in bitwise_pipe_unit.

Test Plan (WIDTH=8, CNT_W=4 unless noted):
1. Per-opcode sweep with A=0xC5, B=0x3A, out_ready=1.
   - Expected results: AND 0x00 (zero=1); OR 0xFF (parity=0); NAND 0xFF; NOR 0x00; XOR 0xFF; XNOR 0x00; NOTA 0x3A; PASSB 0x3A (parity=0).
   - Each result appears exactly 2 cycles after acceptance.
2. Back-to-back stream with 16 consecutive transactions and out_ready=1.
   - One result per cycle, in order.
   - in_ready stays high throughout.
   - op_count saturates at 15 and stays there.
3. Backpressure: send 4 transactions while holding out_ready=0.
   - in_ready falls after 2 are accepted; out_y holds the first result stable.
   - Release out_ready: all 4 results delivered in order with none lost or duplicated.
4. Full-pipe simultaneous event: both stages full, then in_valid=1 and out_ready=1 in the same cycle.
   - Exactly one emit and one accept occur; next cycle out_valid=1 with no bubble.
5. Reset mid-stream: assert rst for 1 cycle with 2 transactions in flight.
   - Next cycle out_valid=0 and op_count=0.
   - The in-flight results never appear; a fresh transaction completes normally.
6. WIDTH=1 build with NOTA, A=0 -> y=1, zero=0, parity=1.
   - Confirms bitwise (not logical) inversion at the minimum width.
